mii_rx_framer: RTL and testbench
================================

// Module: mii_rx_framer
// PURPOSE
//  MII receive framer; successor to the fixed nibble-to-byte assembler.
//  Strips preamble/SFD and packs nibbles (low nibble first) into OUT_BYTES-wide words.
//  Emits a valid-only stream with SOF/EOF/keep/err flags, plus the frame length.
//  Sits between the PHY MII RX pins and the MAC RX FIFO, in the mii_clk domain.
// PARAMETERS
//  OUT_BYTES        4     bytes per output word, 1..4; first byte in bits [7:0]
//  MIN_PRE_NIBBLES  2     minimum number of 0x5 nibbles before SFD nibble 0xD
//  MAX_BYTES        1522  frame byte count above which the frame is flagged oversize
// PORTS
//  mii_clk    in   1            PHY RX clock; all logic on its rising edge
//  reset      in   1            synchronous, active-high
//  mii_en     in   1            RX_DV
//  mii_er     in   1            RX_ER
//  mii_d      in   4            RXD nibble
//  out_valid  out  1            output beat valid (one-cycle pulse, no backpressure)
//  out_data   out  8*OUT_BYTES  packed bytes
//  out_keep   out  OUT_BYTES    byte-valid mask; all ones except possibly on the EOF beat
//  out_sof    out  1            first beat of frame
//  out_eof    out  1            last beat of frame
//  out_err    out  1            frame error; valid on the EOF beat only
//  out_len    out  16           frame byte count (SFD excluded); valid on the EOF beat
//  out_crc_bad out 1            FCS mismatch on the EOF beat (see CONFIGURATION)
// BEHAVIOUR
//  Interface: reset reset, synchronous, active-high; clock mii_clk.
//  Reset: all outputs 0, counters 0, state DROP.
//  States:
//   DROP: ignore input; go to IDLE when mii_en=0.
//   IDLE: on mii_en=1 with mii_d=5, go to PRE (pre_cnt=1); mii_en=1 with any other nibble -> DROP.
//   PRE: 5 -> pre_cnt++ (saturates at 15).
//        D with pre_cnt>=MIN_PRE_NIBBLES -> DATA.
//        Any other nibble, or D too early -> DROP.
//        mii_en=0 -> IDLE; no output.
//   DATA: assemble a byte from each 2 nibbles; pack bytes into the word accumulator.
//  Word emission:
//   A full word is held until the next nibble arrives; it is emitted the following cycle with eof=0.
//   The arriving nibble starts the new accumulator in the same cycle.
//   When mii_en is first sampled 0 in DATA, the held word or partial word is emitted the next cycle with eof=1; state -> IDLE.
//   Each frame produces exactly one EOF beat.
//   out_sof is set on the first emitted beat; sof and eof may coincide.
//  Errors (sticky per frame, reported on the EOF beat via out_err):
//   - mii_er=1 while mii_en=1 in DATA.
//   - Odd nibble count at end of frame; the trailing nibble is dropped.
//   - byte count > MAX_BYTES: further words are suppressed; counting continues, saturating at 16'hFFFF.
//  Zero-byte frame (mii_en falls right after SFD): no beat emitted, no error.
//  mii_er outside DATA is ignored.
//  Reset mid-frame: outputs 0 next cycle; state DROP, so the rest of the in-flight frame is discarded.
//  Back-to-back frames need ≥1 idle mii_clk (mii_en=0). EOF is emitted in that idle cycle.
// CONFIGURATION
//  MII_RX_CRC_EN defined:
//   - Instantiate mii_crc32 over all DATA bytes, FCS included.
//   - On EOF, out_crc_bad=1 when the residue != 32'hC704DD7B; out_err is ORed with out_crc_bad.
//  MII_RX_CRC_EN undefined: no CRC logic; out_crc_bad tied 0.
// STRUCTURE
//  mii_defs.vh (shared): state encodings, PREAMBLE_NIB=4'h5, SFD_NIB=4'hD,
//   CRC32_POLY=32'h04C11DB7, CRC32_RESIDUE=32'hC704DD7B.
//  Sub-module mii_crc32: byte-wide, reflected CRC-32.
//   Ports: clk, reset, init, en, d[7:0], residue_ok.
// TESTING
//  1 Frame 55 55 55 55 55 55 55 D5 + 8 bytes 01..08, OUT_BYTES=4 -> 2 beats:
//     04030201 (sof), 08070605 (eof, keep=F, len=8, err=0).
//  2 Frame with 5 payload bytes -> 2nd beat keep=4'b0001, data[7:0]=05, eof, len=5.
//  3 mii_er pulsed on 3rd payload byte -> normal beats; EOF beat has err=1.
//  4 Preamble nibble 0x7 before SFD -> no output. The next good frame after an idle cycle is received intact.
//  5 Reset asserted mid-payload -> out_valid=0. The remainder is discarded; the following frame decodes correctly.
//  6 MII_RX_CRC_EN: 60-byte frame with correct FCS -> crc_bad=0; one bit flipped -> crc_bad=1, err=1.

Source files
------------

// File: rtl/mii_rx_framer_pkg.sv
// mii_rx_framer_pkg: shared definitions for the MII receive framer.
// Holds the FSM state encoding, the preamble/SFD nibble codes and the
// CRC-32 constants plus byte-wide reflected CRC helpers used by mii_crc32.
package mii_rx_framer_pkg;

  typedef enum logic [1:0] {
    ST_DROP = 2'd0,
    ST_IDLE = 2'd1,
    ST_PRE  = 2'd2,
    ST_DATA = 2'd3
  } rx_state_t;

  localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // One byte of LSB-first (reflected) CRC-32, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic [31:0] poly_r;
    poly_r = bitrev32(CRC32_POLY);
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) begin
        c = (c >> 1) ^ poly_r;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_crc32.sv
// mii_crc32: byte-wide reflected CRC-32 accumulator with residue check.
// Ports: clk, reset (sync, active-high), init (reload all-ones), en (absorb d),
//   d[7:0] data byte, residue_ok (register holds the good-FCS residue).
// Only built when MII_RX_CRC_EN is defined.
`ifdef MII_RX_CRC_EN
module mii_crc32
  import mii_rx_framer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] d,
  output logic       residue_ok
);

  logic [31:0] r_crc;

  always_ff @(posedge clk) begin
    if (reset || init) begin
      r_crc <= '1;
    end else if (en) begin
      r_crc <= crc32_byte(r_crc, d);
    end
  end

  // The register shifts LSB-first, so it holds the bit-reversed form of
  // the conventional (MSB-first) magic residue after a good frame + FCS.
  assign residue_ok = (bitrev32(r_crc) == CRC32_RESIDUE);

endmodule
`endif

// File: rtl/mii_rx_framer.sv
// mii_rx_framer: MII RX framer. Strips preamble/SFD, packs nibbles (low first)
// into OUT_BYTES-wide words and emits a valid-only stream with sof/eof/keep/err
// and the frame byte length on the EOF beat. Output is registered, no backpressure.
// Ports: mii_clk, reset (sync, active-high); mii_en/mii_er/mii_d (PHY RX pins);
//   out_valid/out_data/out_keep/out_sof/out_eof/out_err/out_len/out_crc_bad.
// Optional: define MII_RX_CRC_EN to check the FCS (out_crc_bad, folded into out_err).
module mii_rx_framer
  import mii_rx_framer_pkg::*;
#(
  parameter int OUT_BYTES       = 4,
  parameter int MIN_PRE_NIBBLES = 2,
  parameter int MAX_BYTES       = 1522
) (
  input  logic                   mii_clk,
  input  logic                   reset,
  input  logic                   mii_en,
  input  logic                   mii_er,
  input  logic [3:0]             mii_d,
  output logic                   out_valid,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   out_err,
  output logic [15:0]            out_len,
  output logic                   out_crc_bad
);

  localparam int                CNT_W    = $clog2(OUT_BYTES + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(OUT_BYTES);
  localparam logic [3:0]        MIN_PRE  = 4'(MIN_PRE_NIBBLES);
  localparam logic [15:0]       MAX_LEN  = 16'(MAX_BYTES);

  rx_state_t              r_state, w_state_nxt;
  logic [3:0]             r_pre_cnt, w_pre_cnt_nxt;
  logic [3:0]             r_nib_lo, w_nib_lo_nxt;
  logic                   r_phase, w_phase_nxt;      // 1: low nibble captured
  logic [8*OUT_BYTES-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0]       r_acc_cnt, w_acc_cnt_nxt;  // complete bytes in r_acc
  logic [15:0]            r_len, w_len_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_sof_pend, w_sof_pend_nxt;

  logic                   r_out_valid, w_o_valid;
  logic [8*OUT_BYTES-1:0] r_out_data, w_o_data;
  logic [OUT_BYTES-1:0]   r_out_keep, w_o_keep;
  logic                   r_out_sof, w_o_sof;
  logic                   r_out_eof, w_o_eof;
  logic                   r_out_err, w_o_err;
  logic [15:0]            r_out_len, w_o_len;
  logic                   r_out_crc_bad, w_o_crc_bad;

  logic [7:0]             w_byte;
  logic                   w_over;
  logic                   w_crc_bad;

  assign w_byte = {mii_d, r_nib_lo};
  assign w_over = (r_len > MAX_LEN);

`ifdef MII_RX_CRC_EN
  logic w_crc_init;
  logic w_crc_en;
  logic w_residue_ok;

  assign w_crc_init = (r_state == ST_PRE) && (w_state_nxt == ST_DATA);
  assign w_crc_en   = (r_state == ST_DATA) && mii_en && r_phase;

  mii_crc32 u_crc (
    .clk        (mii_clk),
    .reset      (reset),
    .init       (w_crc_init),
    .en         (w_crc_en),
    .d          (w_byte),
    .residue_ok (w_residue_ok)
  );

  // A zero-byte frame has nothing to check.
  assign w_crc_bad = (r_len != 16'd0) && !w_residue_ok;
`else
  assign w_crc_bad = 1'b0;
`endif

  always_ff @(posedge mii_clk) begin
    if (reset) begin
      r_state <= ST_DROP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pre_cnt_nxt  = r_pre_cnt;
    w_nib_lo_nxt   = r_nib_lo;
    w_phase_nxt    = r_phase;
    w_acc_nxt      = r_acc;
    w_acc_cnt_nxt  = r_acc_cnt;
    w_len_nxt      = r_len;
    w_err_nxt      = r_err;
    w_sof_pend_nxt = r_sof_pend;
    w_o_valid      = 1'b0;
    w_o_data       = '0;
    w_o_keep       = '0;
    w_o_sof        = 1'b0;
    w_o_eof        = 1'b0;
    w_o_err        = 1'b0;
    w_o_len        = '0;
    w_o_crc_bad    = 1'b0;

    case (r_state)
      ST_DROP: begin
        if (!mii_en) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (mii_en) begin
          if (mii_d == PREAMBLE_NIB) begin
            w_state_nxt   = ST_PRE;
            w_pre_cnt_nxt = 4'd1;
          end else begin
            w_state_nxt = ST_DROP;
          end
        end
      end

      ST_PRE: begin
        if (!mii_en) begin
          w_state_nxt = ST_IDLE;
        end else if (mii_d == PREAMBLE_NIB) begin
          if (r_pre_cnt != 4'hF) begin
            w_pre_cnt_nxt = r_pre_cnt + 4'd1;
          end
        end else if ((mii_d == SFD_NIB) && (r_pre_cnt >= MIN_PRE)) begin
          w_state_nxt    = ST_DATA;
          w_acc_nxt      = '0;
          w_acc_cnt_nxt  = '0;
          w_len_nxt      = '0;
          w_err_nxt      = 1'b0;
          w_phase_nxt    = 1'b0;
          w_sof_pend_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end

      ST_DATA: begin
        if (mii_en) begin
          if (mii_er) begin
            w_err_nxt = 1'b1;
          end
          if (!r_phase) begin
            w_nib_lo_nxt = mii_d;
            w_phase_nxt  = 1'b1;
            // A full word waits for this nibble so the final word of a
            // frame can still be flagged as EOF when mii_en drops instead.
            if (r_acc_cnt == FULL_CNT) begin
              w_acc_nxt     = '0;
              w_acc_cnt_nxt = '0;
              if (!w_over) begin
                w_o_valid      = 1'b1;
                w_o_data       = r_acc;
                w_o_keep       = '1;
                w_o_sof        = r_sof_pend;
                w_sof_pend_nxt = 1'b0;
              end
            end
          end else begin
            w_phase_nxt = 1'b0;
            for (int i = 0; i < OUT_BYTES; i++) begin
              if (r_acc_cnt == CNT_W'(i)) begin
                w_acc_nxt[8*i +: 8] = w_byte;
              end
            end
            w_acc_cnt_nxt = r_acc_cnt + CNT_W'(1);
            if (r_len != 16'hFFFF) begin
              w_len_nxt = r_len + 16'd1;
            end
          end
        end else begin
          w_state_nxt = ST_IDLE;
          // Clean zero-byte frames vanish; an errored one still gets an
          // EOF beat (keep all zero) so the error is not lost.
          if ((r_acc_cnt != '0) || r_err || r_phase) begin
            w_o_valid = 1'b1;
            w_o_data  = r_acc;
            for (int i = 0; i < OUT_BYTES; i++) begin
              w_o_keep[i] = (CNT_W'(i) < r_acc_cnt);
            end
            w_o_sof     = r_sof_pend;
            w_o_eof     = 1'b1;
            w_o_len     = r_len;
            w_o_crc_bad = w_crc_bad;
            w_o_err     = r_err | r_phase | w_over | w_crc_bad;
          end
        end
      end

      default: begin
        w_state_nxt = ST_DROP;
      end
    endcase
  end

  always_ff @(posedge mii_clk) begin
    if (reset) begin
      r_pre_cnt     <= '0;
      r_nib_lo      <= '0;
      r_phase       <= 1'b0;
      r_acc         <= '0;
      r_acc_cnt     <= '0;
      r_len         <= '0;
      r_err         <= 1'b0;
      r_sof_pend    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_keep    <= '0;
      r_out_sof     <= 1'b0;
      r_out_eof     <= 1'b0;
      r_out_err     <= 1'b0;
      r_out_len     <= '0;
      r_out_crc_bad <= 1'b0;
    end else begin
      r_pre_cnt     <= w_pre_cnt_nxt;
      r_nib_lo      <= w_nib_lo_nxt;
      r_phase       <= w_phase_nxt;
      r_acc         <= w_acc_nxt;
      r_acc_cnt     <= w_acc_cnt_nxt;
      r_len         <= w_len_nxt;
      r_err         <= w_err_nxt;
      r_sof_pend    <= w_sof_pend_nxt;
      r_out_valid   <= w_o_valid;
      r_out_data    <= w_o_data;
      r_out_keep    <= w_o_keep;
      r_out_sof     <= w_o_sof;
      r_out_eof     <= w_o_eof;
      r_out_err     <= w_o_err;
      r_out_len     <= w_o_len;
      r_out_crc_bad <= w_o_crc_bad;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_keep    = r_out_keep;
  assign out_sof     = r_out_sof;
  assign out_eof     = r_out_eof;
  assign out_err     = r_out_err;
  assign out_len     = r_out_len;
  assign out_crc_bad = r_out_crc_bad;

endmodule

// File: tb/tb_mii_rx_framer.sv
// tb_mii_rx_framer: self-checking bench for mii_rx_framer (OUT_BYTES=4).
// A table of frame descriptors with expected beat count, last keep, length and
// error is replayed, followed by hand-written reset/back-to-back/CRC sequences.
module tb_mii_rx_framer;

  localparam int OB = 4;
`ifdef MII_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic          mii_clk = 1'b0;
  logic          reset;
  logic          mii_en;
  logic          mii_er;
  logic [3:0]    mii_d;
  logic          out_valid;
  logic [8*OB-1:0] out_data;
  logic [OB-1:0] out_keep;
  logic          out_sof;
  logic          out_eof;
  logic          out_err;
  logic [15:0]   out_len;
  logic          out_crc_bad;

  mii_rx_framer #(.OUT_BYTES(OB), .MIN_PRE_NIBBLES(2), .MAX_BYTES(1522)) dut (
    .mii_clk     (mii_clk),
    .reset       (reset),
    .mii_en      (mii_en),
    .mii_er      (mii_er),
    .mii_d       (mii_d),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_keep    (out_keep),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_err     (out_err),
    .out_len     (out_len),
    .out_crc_bad (out_crc_bad)
  );

  always #5 mii_clk = ~mii_clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        sof;
    logic        eof;
    logic        err;
    logic        crc;
    logic [15:0] len;
  } beat_t;

  typedef struct {
    int         pre_n;
    bit         bad_pre;
    int         nbytes;
    int         er_byte;
    bit         odd;
    int         beats;     // -1: count not checked
    logic [3:0] keep;
    int         len;
    bit         err;
  } vec_t;

  localparam int NV = 14;

  beat_t      q[$];
  beat_t      mon_b;
  logic [7:0] tx_buf [0:2047];
  vec_t       vecs [NV];
  int         n_checks = 0;
  int         n_errors = 0;

  always @(negedge mii_clk) begin
    if (out_valid === 1'b1) begin
      mon_b.data = out_data;
      mon_b.keep = out_keep;
      mon_b.sof  = out_sof;
      mon_b.eof  = out_eof;
      mon_b.err  = out_err;
      mon_b.crc  = out_crc_bad;
      mon_b.len  = out_len;
      q.push_back(mon_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_nib(input logic en, input logic er, input logic [3:0] d);
    mii_en = en;
    mii_er = er;
    mii_d  = d;
    @(posedge mii_clk);
    #1;
  endtask

  task automatic send_frame(input int pre_n, input bit bad_pre, input int nbytes,
                            input int er_byte, input bit odd, input int idle_n);
    logic [7:0] by;
    logic       e;
    for (int i = 0; i < pre_n; i++) drive_nib(1'b1, 1'b0, 4'h5);
    if (bad_pre) drive_nib(1'b1, 1'b0, 4'h7);
    drive_nib(1'b1, 1'b0, 4'hD);
    for (int k = 0; k < nbytes; k++) begin
      by = tx_buf[k];
      e  = (k == er_byte);
      drive_nib(1'b1, e, by[3:0]);
      drive_nib(1'b1, e, by[7:4]);
    end
    if (odd) drive_nib(1'b1, 1'b0, 4'hA);
    for (int i = 0; i < idle_n; i++) drive_nib(1'b0, 1'b0, 4'h0);
  endtask

  // Compares the collected beats against tx_buf and the expected EOF fields.
  task automatic check_frame(input string tag, input int exp_beats, input logic [3:0] last_keep,
                             input int exp_len, input bit exp_err, input bit exp_crc);
    int         nb;
    int         neof;
    logic [31:0] ew;
    logic [31:0] aw;
    logic [3:0]  ek;
    bit          last;
    nb = q.size();
    if (exp_beats >= 0) chk($sformatf("%s beats", tag), nb, exp_beats);
    neof = 0;
    for (int j = 0; j < nb; j++) if (q[j].eof) neof++;
    chk($sformatf("%s eof_count", tag), neof, (exp_beats == 0) ? 0 : 1);
    for (int j = 0; j < nb; j++) begin
      last = (j == nb - 1);
      if (exp_beats >= 0) begin
        ek = last ? last_keep : 4'hF;
        ew = '0;
        aw = '0;
        for (int bi = 0; bi < OB; bi++) begin
          if (ek[bi]) begin
            ew[8*bi +: 8] = tx_buf[OB*j + bi];
            aw[8*bi +: 8] = q[j].data[8*bi +: 8];
          end
        end
        chk($sformatf("%s beat%0d data", tag, j), aw, ew);
        chk($sformatf("%s beat%0d keep", tag, j), q[j].keep, ek);
        chk($sformatf("%s beat%0d sof", tag, j), q[j].sof, (j == 0));
      end
      if (last) begin
        chk($sformatf("%s eof", tag), q[j].eof, 1);
        chk($sformatf("%s len", tag), q[j].len, exp_len);
        chk($sformatf("%s err", tag), q[j].err, exp_err);
        chk($sformatf("%s crc_bad", tag), q[j].crc, exp_crc);
      end
    end
    q.delete();
  endtask

`ifdef MII_RX_CRC_EN
  function automatic logic [31:0] crc_calc(input int n);
    logic [31:0] c;
    logic [7:0]  by;
    c = '1;
    for (int k = 0; k < n; k++) begin
      by = tx_buf[k];
      for (int bi = 0; bi < 8; bi++) begin
        if (c[0] ^ by[bi]) c = (c >> 1) ^ 32'hEDB88320;
        else               c = c >> 1;
      end
    end
    return c;
  endfunction
`endif

  initial begin
    bit         ce;
`ifdef MII_RX_CRC_EN
    logic [31:0] fcs;
`endif
    //          pre bad  n     er  odd beats keep  len   err
    vecs[0]  = '{15, 1'b0, 8,    -1, 1'b0, 2,   4'hF, 8,    1'b0};
    vecs[1]  = '{15, 1'b0, 5,    -1, 1'b0, 2,   4'h1, 5,    1'b0};
    vecs[2]  = '{15, 1'b0, 8,     2, 1'b0, 2,   4'hF, 8,    1'b1};
    vecs[3]  = '{15, 1'b1, 8,    -1, 1'b0, 0,   4'h0, 0,    1'b0};
    vecs[4]  = '{15, 1'b0, 8,    -1, 1'b0, 2,   4'hF, 8,    1'b0};
    vecs[5]  = '{2,  1'b0, 2,    -1, 1'b0, 1,   4'h3, 2,    1'b0};
    vecs[6]  = '{1,  1'b0, 4,    -1, 1'b0, 0,   4'h0, 0,    1'b0};
    vecs[7]  = '{16, 1'b0, 4,    -1, 1'b0, 1,   4'hF, 4,    1'b0};
    vecs[8]  = '{15, 1'b0, 1,    -1, 1'b0, 1,   4'h1, 1,    1'b0};
    vecs[9]  = '{15, 1'b0, 0,    -1, 1'b0, 0,   4'h0, 0,    1'b0};
    vecs[10] = '{15, 1'b0, 3,    -1, 1'b1, 1,   4'h7, 3,    1'b1};
    vecs[11] = '{15, 1'b0, 12,   -1, 1'b0, 3,   4'hF, 12,   1'b0};
    vecs[12] = '{15, 1'b0, 1522, -1, 1'b0, 381, 4'h3, 1522, 1'b0};
    vecs[13] = '{15, 1'b0, 1523, -1, 1'b0, -1,  4'h0, 1523, 1'b1};

    reset  = 1'b1;
    mii_en = 1'b0;
    mii_er = 1'b0;
    mii_d  = 4'h0;
    repeat (3) @(posedge mii_clk);
    @(negedge mii_clk);
    chk("reset valid", out_valid, 0);
    chk("reset data", out_data, 0);
    chk("reset keep", out_keep, 0);
    chk("reset sof", out_sof, 0);
    chk("reset eof", out_eof, 0);
    chk("reset err", out_err, 0);
    chk("reset len", out_len, 0);
    chk("reset crc_bad", out_crc_bad, 0);
    @(posedge mii_clk);
    #1;
    reset = 1'b0;
    drive_nib(1'b0, 1'b0, 4'h0);
    drive_nib(1'b0, 1'b0, 4'h0);
    q.delete();

    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < vecs[v].nbytes; k++) tx_buf[k] = 8'(k + 1 + 16 * v);
      send_frame(vecs[v].pre_n, vecs[v].bad_pre, vecs[v].nbytes, vecs[v].er_byte, vecs[v].odd, 3);
      // Table frames carry no FCS, so with CRC checking every non-empty one is flagged.
      ce = CRC_ON && (vecs[v].nbytes > 0);
      check_frame($sformatf("vec%0d", v), vecs[v].beats, vecs[v].keep, vecs[v].len,
                  vecs[v].err | ce, ce);
    end

    // Reset lands on the edge that would emit the first full word.
    for (int k = 0; k < 8; k++) tx_buf[k] = 8'(8'hA0 + k);
    for (int i = 0; i < 15; i++) drive_nib(1'b1, 1'b0, 4'h5);
    drive_nib(1'b1, 1'b0, 4'hD);
    for (int k = 0; k < 4; k++) begin
      drive_nib(1'b1, 1'b0, tx_buf[k][3:0]);
      drive_nib(1'b1, 1'b0, tx_buf[k][7:4]);
    end
    reset = 1'b1;
    drive_nib(1'b1, 1'b0, 4'h4);
    @(negedge mii_clk);
    chk("rst_mid valid", out_valid, 0);
    chk("rst_mid sof", out_sof, 0);
    reset = 1'b0;
    drive_nib(1'b1, 1'b0, 4'hA);
    for (int k = 5; k < 8; k++) begin
      drive_nib(1'b1, 1'b0, tx_buf[k][3:0]);
      drive_nib(1'b1, 1'b0, tx_buf[k][7:4]);
    end
    for (int i = 0; i < 3; i++) drive_nib(1'b0, 1'b0, 4'h0);
    chk("rst_mid beats", q.size(), 0);
    q.delete();
    for (int k = 0; k < 8; k++) tx_buf[k] = 8'(k + 1);
    send_frame(15, 1'b0, 8, -1, 1'b0, 3);
    ce = CRC_ON;
    check_frame("post_rst", 2, 4'hF, 8, ce, ce);

    // Back-to-back frames separated by a single idle cycle.
    for (int k = 0; k < 4; k++) tx_buf[k] = 8'(8'hC0 + k);
    send_frame(15, 1'b0, 4, -1, 1'b0, 1);
    send_frame(15, 1'b0, 4, -1, 1'b0, 3);
    chk("b2b beats", q.size(), 2);
    for (int j = 0; j < q.size(); j++) begin
      chk($sformatf("b2b beat%0d data", j), q[j].data, 32'hC3C2C1C0);
      chk($sformatf("b2b beat%0d sof", j), q[j].sof, 1);
      chk($sformatf("b2b beat%0d eof", j), q[j].eof, 1);
      chk($sformatf("b2b beat%0d len", j), q[j].len, 4);
    end
    q.delete();

`ifdef MII_RX_CRC_EN
    for (int k = 0; k < 56; k++) tx_buf[k] = 8'(k * 7 + 3);
    fcs = ~crc_calc(56);
    tx_buf[56] = fcs[7:0];
    tx_buf[57] = fcs[15:8];
    tx_buf[58] = fcs[23:16];
    tx_buf[59] = fcs[31:24];
    send_frame(15, 1'b0, 60, -1, 1'b0, 3);
    check_frame("crc_good", 15, 4'hF, 60, 1'b0, 1'b0);
    tx_buf[10] = tx_buf[10] ^ 8'h04;
    send_frame(15, 1'b0, 60, -1, 1'b0, 3);
    check_frame("crc_flip", 15, 4'hF, 60, 1'b1, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
